sobel_window_collector: RTL and testbench



---
 rtl/sobel_pkg.sv | 20 ++
 rtl/sobel_window_collector.sv | 143 ++++++++++++++
 tb/tb_sobel_window_collector.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel front-end blocks.
package sobel_pkg;

  localparam int SOBEL_PX_WIDTH = 8;
  localparam int SOBEL_WIN_PX   = 9;

  typedef enum logic [1:0] {SW_IDLE, SW_FILL, SW_WAIT, SW_SHIFT_FILL} sobel_win_state_t;

  typedef logic [SOBEL_PX_WIDTH-1:0] sobel_px_t;

  // Column-major fill: pixel k lands in column k/3, row k%3.
  function automatic logic [1:0] fill_col(input logic [3:0] k);
    return 2'(k / 4'd3);
  endfunction

  function automatic logic [1:0] fill_row(input logic [3:0] k);
    return 2'(k % 4'd3);
  endfunction

endpackage

// File: rtl/sobel_window_collector.sv
// Collects a serial gray-pixel stream into a 3x3 window with sliding-column reuse.
// Optional saturating consumed-window counter enabled by macro SOBEL_WIN_COUNT_EN.
module sobel_window_collector
  import sobel_pkg::*;
#(
  parameter int PX_WIDTH  = SOBEL_PX_WIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [PX_WIDTH-1:0]              px_data_i,
  input  logic                             px_valid_i,
  output logic                             px_ready_o,
  input  logic                             restart_i,
  output logic [SOBEL_WIN_PX*PX_WIDTH-1:0] window_o,
  output logic                             window_valid_o,
  input  logic                             window_ready_i,
  output logic [CNT_WIDTH-1:0]             win_count_o
);

  sobel_win_state_t    state, state_n;
  logic [3:0]          cnt, cnt_n;
  logic [PX_WIDTH-1:0] win [3][3];
  logic                valid_q;
  logic                wr_en;
  logic                shift;
  logic [1:0]          wr_col;
  logic [1:0]          wr_row;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    px_ready_o = 1'b0;
    wr_en      = 1'b0;
    shift      = 1'b0;
    wr_col     = 2'd0;
    wr_row     = 2'd0;
    case (state)
      SW_IDLE: begin
        state_n = SW_FILL;
        cnt_n   = '0;
      end
      SW_FILL: begin
        px_ready_o = !restart_i;
        wr_col     = fill_col(cnt);
        wr_row     = fill_row(cnt);
        if (px_valid_i && !restart_i) begin
          wr_en = 1'b1;
          if (cnt == 4'd8) begin
            state_n = SW_WAIT;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
      end
      SW_WAIT: begin
        if (window_ready_i && !restart_i) begin
          shift   = 1'b1;
          state_n = SW_SHIFT_FILL;
          cnt_n   = '0;
        end
      end
      SW_SHIFT_FILL: begin
        px_ready_o = !restart_i;
        wr_col     = 2'd2;
        wr_row     = cnt[1:0];
        if (px_valid_i && !restart_i) begin
          wr_en = 1'b1;
          if (cnt == 4'd2) begin
            state_n = SW_WAIT;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
      end
      default: begin
        state_n = SW_IDLE;
        cnt_n   = '0;
      end
    endcase
    // Restart outranks any consume or accept decided above; the window contents are kept.
    if (state != SW_IDLE && restart_i) begin
      state_n = SW_FILL;
      cnt_n   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= SW_IDLE;
      cnt     <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      valid_q <= (state_n == SW_WAIT);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned c = 0; c < 3; c++)
        for (int unsigned r = 0; r < 3; r++)
          win[c][r] <= '0;
    end else if (shift) begin
      // Column 2 keeps stale data until the next three pixels overwrite it.
      for (int unsigned r = 0; r < 3; r++) begin
        win[0][r] <= win[1][r];
        win[1][r] <= win[2][r];
      end
    end else if (wr_en) begin
      win[wr_col][wr_row] <= px_data_i;
    end
  end

  always_comb begin
    window_o = '0;
    for (int unsigned r = 0; r < 3; r++)
      for (int unsigned c = 0; c < 3; c++)
        window_o[(r*3+c)*PX_WIDTH +: PX_WIDTH] = win[c][r];
  end

  assign window_valid_o = valid_q;

`ifdef SOBEL_WIN_COUNT_EN
  logic [CNT_WIDTH-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (shift && count_q != '1) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign win_count_o = count_q;
`else
  assign win_count_o = '0;
`endif

endmodule

// File: tb/tb_sobel_window_collector.sv
// Directed self-checking bench for sobel_window_collector (counter checks follow SOBEL_WIN_COUNT_EN).
module tb_sobel_window_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  px_data;
  logic        px_valid;
  logic        px_ready;
  logic        restart;
  logic [71:0] window;
  logic        window_valid;
  logic        window_ready;
  logic [1:0]  win_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_cnt = 2'd0;

  always #5 clk = ~clk;

  sobel_window_collector #(.PX_WIDTH(8), .CNT_WIDTH(2)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .px_data_i      (px_data),
    .px_valid_i     (px_valid),
    .px_ready_o     (px_ready),
    .restart_i      (restart),
    .window_o       (window),
    .window_valid_o (window_valid),
    .window_ready_i (window_ready),
    .win_count_o    (win_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected window for column-major pixels base, base+1, ... base+8.
  function automatic logic [71:0] mkwin(input logic [7:0] base);
    logic [71:0] w;
    w = '0;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++)
        w[(r*3+c)*8 +: 8] = base + 8'(c*3+r);
    return w;
  endfunction

  task automatic fill9(input logic [7:0] base);
    for (int k = 0; k < 9; k++) begin
      px_valid = 1'b1;
      px_data  = base + 8'(k);
      tick();
    end
    px_valid = 1'b0;
  endtask

  task automatic consume;
    window_ready = 1'b1;
    tick();
    window_ready = 1'b0;
`ifdef SOBEL_WIN_COUNT_EN
    if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
`endif
  endtask

  task automatic test_reset;
    reset = 1'b1; restart = 1'b1; px_valid = 1'b1; px_data = 8'hAA; window_ready = 1'b1;
    tick(); tick();
    n_checks++; if (window_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b want 0", window_valid); end
    n_checks++; if (px_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready got %b want 0", px_ready); end
    n_checks++; if (window !== 72'h0) begin n_errors++; $display("FAIL reset_window got %h want 0", window); end
    n_checks++; if (win_count !== 2'd0) begin n_errors++; $display("FAIL reset_count got %0d want 0", win_count); end
    reset = 1'b0; restart = 1'b0; px_valid = 1'b0; window_ready = 1'b0;
    tick();
    n_checks++; if (px_ready !== 1'b1) begin n_errors++; $display("FAIL idle_to_fill_ready got %b want 1", px_ready); end
  endtask

  task automatic test_fill;
    for (int k = 0; k < 9; k++) begin
      px_valid = 1'b1;
      px_data  = 8'(k + 1);
      tick();
      if (k == 7) begin
        n_checks++; if (window_valid !== 1'b0) begin n_errors++; $display("FAIL fill_early_valid got %b want 0", window_valid); end
      end
    end
    n_checks++; if (window_valid !== 1'b1) begin n_errors++; $display("FAIL fill_valid got %b want 1", window_valid); end
    n_checks++; if (window !== mkwin(8'h01)) begin n_errors++; $display("FAIL fill_window got %h want %h", window, mkwin(8'h01)); end
    n_checks++; if (px_ready !== 1'b0) begin n_errors++; $display("FAIL fill_wait_ready got %b want 0", px_ready); end
    px_valid = 1'b0;
  endtask

  task automatic test_slide;
    consume();
    n_checks++; if (window_valid !== 1'b0) begin n_errors++; $display("FAIL slide_drop got %b want 0", window_valid); end
    n_checks++; if (px_ready !== 1'b1) begin n_errors++; $display("FAIL slide_ready got %b want 1", px_ready); end
    n_checks++; if (win_count !== exp_cnt) begin n_errors++; $display("FAIL slide_count got %0d want %0d", win_count, exp_cnt); end
    window_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      px_valid = 1'b1;
      px_data  = 8'h0A + 8'(k);
      tick();
      if (k == 1) begin
        n_checks++; if (window_valid !== 1'b0) begin n_errors++; $display("FAIL slide_early_valid got %b want 0", window_valid); end
      end
    end
    window_ready = 1'b0; px_valid = 1'b0;
    n_checks++; if (window_valid !== 1'b1) begin n_errors++; $display("FAIL slide_valid got %b want 1", window_valid); end
    n_checks++; if (window !== mkwin(8'h04)) begin n_errors++; $display("FAIL slide_window got %h want %h", window, mkwin(8'h04)); end
  endtask

  task automatic test_hold;
    window_ready = 1'b0; px_valid = 1'b1; px_data = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++; if (window !== mkwin(8'h04)) begin n_errors++; $display("FAIL hold_window cyc %0d got %h want %h", i, window, mkwin(8'h04)); end
      n_checks++; if (px_ready !== 1'b0) begin n_errors++; $display("FAIL hold_ready cyc %0d got %b want 0", i, px_ready); end
      n_checks++; if (window_valid !== 1'b1) begin n_errors++; $display("FAIL hold_valid cyc %0d got %b want 1", i, window_valid); end
    end
    px_valid = 1'b0;
  endtask

  task automatic test_restart_consume;
    window_ready = 1'b1; restart = 1'b1; px_valid = 1'b1; px_data = 8'hEE;
    #1;
    n_checks++; if (px_ready !== 1'b0) begin n_errors++; $display("FAIL rc_ready got %b want 0", px_ready); end
    tick();
    window_ready = 1'b0; restart = 1'b0; px_valid = 1'b0;
    n_checks++; if (window_valid !== 1'b0) begin n_errors++; $display("FAIL rc_valid got %b want 0", window_valid); end
    n_checks++; if (window !== mkwin(8'h04)) begin n_errors++; $display("FAIL rc_kept got %h want %h", window, mkwin(8'h04)); end
    n_checks++; if (win_count !== exp_cnt) begin n_errors++; $display("FAIL rc_count got %0d want %0d", win_count, exp_cnt); end
    fill9(8'h11);
    n_checks++; if (window_valid !== 1'b1) begin n_errors++; $display("FAIL rc_refill_valid got %b want 1", window_valid); end
    n_checks++; if (window !== mkwin(8'h11)) begin n_errors++; $display("FAIL rc_refill got %h want %h", window, mkwin(8'h11)); end
  endtask

  task automatic test_restart_fill;
    consume();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    for (int k = 0; k < 5; k++) begin
      px_valid = 1'b1;
      px_data  = 8'h21 + 8'(k);
      tick();
    end
    restart = 1'b1; px_data = 8'hEE;
    tick();
    restart = 1'b0; px_valid = 1'b0;
    n_checks++; if (window_valid !== 1'b0) begin n_errors++; $display("FAIL rf_valid got %b want 0", window_valid); end
    fill9(8'h31);
    n_checks++; if (window_valid !== 1'b1) begin n_errors++; $display("FAIL rf_refill_valid got %b want 1", window_valid); end
    n_checks++; if (window !== mkwin(8'h31)) begin n_errors++; $display("FAIL rf_refill got %h want %h", window, mkwin(8'h31)); end
  endtask

  task automatic test_reset_mid;
    consume();
    px_valid = 1'b1; px_data = 8'h41;
    tick();
    reset = 1'b1; restart = 1'b1; px_data = 8'h42;
    tick();
    exp_cnt = 2'd0;
    restart = 1'b0;
    n_checks++; if (window_valid !== 1'b0) begin n_errors++; $display("FAIL rm_valid got %b want 0", window_valid); end
    n_checks++; if (px_ready !== 1'b0) begin n_errors++; $display("FAIL rm_ready got %b want 0", px_ready); end
    n_checks++; if (window !== 72'h0) begin n_errors++; $display("FAIL rm_window got %h want 0", window); end
    n_checks++; if (win_count !== 2'd0) begin n_errors++; $display("FAIL rm_count got %0d want 0", win_count); end
    reset = 1'b0; px_valid = 1'b0;
    tick();
    fill9(8'h51);
    n_checks++; if (window_valid !== 1'b1) begin n_errors++; $display("FAIL rm_refill_valid got %b want 1", window_valid); end
    n_checks++; if (window !== mkwin(8'h51)) begin n_errors++; $display("FAIL rm_refill got %h want %h", window, mkwin(8'h51)); end
  endtask

  task automatic test_win_count;
    for (int w = 0; w < 5; w++) begin
      consume();
      n_checks++; if (win_count !== exp_cnt) begin n_errors++; $display("FAIL wc_consume%0d got %0d want %0d", w, win_count, exp_cnt); end
      if (w < 4) begin
        for (int k = 0; k < 3; k++) begin
          px_valid = 1'b1;
          px_data  = 8'h60 + 8'(w*3+k);
          tick();
        end
        px_valid = 1'b0;
      end
    end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    n_checks++; if (win_count !== exp_cnt) begin n_errors++; $display("FAIL wc_restart got %0d want %0d", win_count, exp_cnt); end
    fill9(8'h71);
    consume();
    n_checks++; if (win_count !== exp_cnt) begin n_errors++; $display("FAIL wc_final got %0d want %0d", win_count, exp_cnt); end
  endtask

  initial begin
    reset = 1'b1; restart = 1'b0; px_valid = 1'b0; px_data = 8'h00; window_ready = 1'b0;
    test_reset();
    test_fill();
    test_slide();
    test_hold();
    test_restart_consume();
    test_restart_fill();
    test_reset_mid();
    test_win_count();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
